// File: rtl/secded72_pkg.sv
// Shared constants and position mapping for the 72/64 SECDED encoder and decoder.
// Hamming positions 1..71; check bits at powers of two, overall parity at 0.
package secded72_pkg;

    localparam int DATA_W = 64;
    localparam int CODE_W = 72;
    localparam int CHK_W  = 7;

    localparam int unsigned CHK_POS [CHK_W] = '{1, 2, 4, 8, 16, 32, 64};

    function automatic logic is_chk_pos(input int unsigned p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // Hamming position of data bit idx (3, 5, 6, 7, 9, ...)
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned n;
        int unsigned r;
        n = 0;
        r = 0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (!is_chk_pos(p)) begin
                if (n == idx) r = p;
                n++;
            end
        end
        return r;
    endfunction

    // Data bits placed at their positions; check and parity slots left 0
    function automatic logic [CODE_W-1:0] scatter(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] w;
        int n;
        w = '0;
        n = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if (!is_chk_pos(p)) begin
                w[p[6:0]] = d[n[5:0]];
                n++;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/secded72_parity.sv
// Combinational Hamming check-bit generator for a 64-bit data word.
// Check bit k covers every position whose index has bit k set.
module secded72_parity
    import secded72_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  chk
);

    logic [CODE_W-1:0] w;

    // XOR the covered data positions into each check bit
    always_comb begin
        w   = scatter(data);
        chk = '0;
        for (int k = 0; k < CHK_W; k++) begin
            for (int p = 1; p < CODE_W; p++) begin
                if ((((p >> k) & 1) != 0) && (p != (1 << k))) begin
                    chk[k[2:0]] = chk[k[2:0]] ^ w[p[6:0]];
                end
            end
        end
    end

endmodule

// File: rtl/secded_enc72.sv
// Two-stage pipelined 72/64 SECDED encoder with valid/ready handshakes.
// Optional decoder-test error injection with macro SECDED_ERR_INJ_EN.
module secded_enc72
    import secded72_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              NSYSRESET,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef SECDED_ERR_INJ_EN
    input  logic              inj_en,
    input  logic [6:0]        inj_pos0,
    input  logic [6:0]        inj_pos1,
    input  logic              inj_dbl,
`endif
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
);

    logic              rdy_q;
    logic              s1_v;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_chk;
    logic [CODE_W-1:0] s1_flip;
    logic              s2_v;
    logic [CODE_W-1:0] s2_code;
    logic [CNT_W-1:0]  cnt_q;
    logic [CHK_W-1:0]  in_chk;
    logic [CODE_W-1:0] in_flip;
    logic [CODE_W-1:0] pack;
    logic              s1_ld;
    logic              s2_ld;
    logic              acc;
    logic              dlv;

    secded72_parity u_parity (
        .data (in_data),
        .chk  (in_chk)
    );

    assign s2_ld    = !s2_v || out_ready;
    assign s1_ld    = !s1_v || s2_ld;
    assign in_ready = rdy_q && s1_ld;
    assign acc      = in_valid && in_ready;
    assign dlv      = s2_v && out_ready;

    assign out_valid = s2_v;
    assign out_code  = s2_code;
    assign word_cnt  = cnt_q;

`ifdef SECDED_ERR_INJ_EN
    // Flip mask captured with the word; out-of-range positions drop out
    always_comb begin
        in_flip = '0;
        if (inj_en) begin
            if (inj_pos0 < 7'd72) in_flip[inj_pos0] = 1'b1;
            if (inj_dbl && (inj_pos1 < 7'd72)) in_flip[inj_pos1] = 1'b1;
        end
    end
`else
    assign in_flip = '0;
`endif

    // Assemble the codeword from stage-1 data and check bits
    always_comb begin
        logic [6:0] pos;
        pack = scatter(s1_data);
        for (int k = 0; k < CHK_W; k++) begin
            pos       = 7'(CHK_POS[k]);
            pack[pos] = s1_chk[k[2:0]];
        end
        pack[0] = ^pack[CODE_W-1:1];
        pack    = pack ^ s1_flip;
    end

    // Input side opens one edge after reset release
    always_ff @(posedge clk or negedge NSYSRESET) begin
        if (!NSYSRESET) rdy_q <= 1'b0;
        else            rdy_q <= 1'b1;
    end

    // Stage 1: register data, check bits and injection mask
    always_ff @(posedge clk or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_chk  <= '0;
            s1_flip <= '0;
        end else if (s1_ld) begin
            s1_v <= acc;
            if (acc) begin
                s1_data <= in_data;
                s1_chk  <= in_chk;
                s1_flip <= in_flip;
            end
        end
    end

    // Stage 2: register the packed codeword, held while stalled
    always_ff @(posedge clk or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            s2_v    <= 1'b0;
            s2_code <= '0;
        end else if (s2_ld) begin
            s2_v <= s1_v;
            if (s1_v) s2_code <= pack;
        end
    end

    // Saturating count of delivered codewords
    always_ff @(posedge clk or negedge NSYSRESET) begin
        if (!NSYSRESET)                 cnt_q <= '0;
        else if (dlv && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_secded_enc72.sv
// Directed bench for secded_enc72; builds with or without SECDED_ERR_INJ_EN.
// A second instance with CNT_W=4 shares the inputs for the saturation case.
module tb_secded_enc72;

    logic        clk = 1'b0;
    logic        NSYSRESET = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, in_ready4;
    logic [71:0] out_code, out_code4;
    logic        out_valid, out_valid4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
`ifdef SECDED_ERR_INJ_EN
    logic        inj_en = 1'b0;
    logic [6:0]  inj_pos0 = '0;
    logic [6:0]  inj_pos1 = '0;
    logic        inj_dbl = 1'b0;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    secded_enc72 dut (
        .clk       (clk),
        .NSYSRESET (NSYSRESET),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef SECDED_ERR_INJ_EN
        .inj_en    (inj_en),
        .inj_pos0  (inj_pos0),
        .inj_pos1  (inj_pos1),
        .inj_dbl   (inj_dbl),
`endif
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    secded_enc72 #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .NSYSRESET (NSYSRESET),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef SECDED_ERR_INJ_EN
        .inj_en    (inj_en),
        .inj_pos0  (inj_pos0),
        .inj_pos1  (inj_pos1),
        .inj_dbl   (inj_dbl),
`endif
        .in_ready  (in_ready4),
        .out_code  (out_code4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .word_cnt  (word_cnt4)
    );

    function automatic logic [63:0] tb_extract(input logic [71:0] c);
        logic [63:0] r;
        int n;
        r = '0;
        n = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                r[n[5:0]] = c[p[6:0]];
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] tb_syndrome(input logic [71:0] c);
        logic [6:0] s;
        s = '0;
        for (int p = 1; p < 72; p++) begin
            if (c[p[6:0]]) s = s ^ p[6:0];
        end
        return s;
    endfunction

    task automatic test_reset;
        #1 NSYSRESET = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 16'd0) $display("FAIL reset_word_cnt got %0d want 0", word_cnt);
        else n_pass++;
        n_checks++;
        if (out_code !== 72'h0) $display("FAIL reset_out_code got %h want 0", out_code);
        else n_pass++;
        @(negedge clk);
        NSYSRESET = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_zero;
        out_ready = 1'b1;
        in_data   = 64'h0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL zero_lat1 out_valid got %b want 0", out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 72'h0)
            $display("FAIL zero_code got v=%b %h want v=1 0", out_valid, out_code);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (word_cnt !== 16'd1) $display("FAIL zero_word_cnt got %0d want 1", word_cnt);
        else n_pass++;
    endtask

    task automatic test_vectors;
        logic [63:0] d [4];
        logic [71:0] c [4];
        d[0] = 64'h1;                 c[0] = 72'h00_0000_0000_0000_000F;
        d[1] = 64'h2;                 c[1] = 72'h00_0000_0000_0000_0033;
        d[2] = 64'h8000_0000_0000_0000; c[2] = 72'h81_0000_0000_0000_0017;
        d[3] = 64'hFFFF_FFFF_FFFF_FFFF; c[3] = 72'hFF_FFFF_FFFF_FFFF_FFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data  = d[i];
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_code !== c[i])
                $display("FAIL vector%0d got v=%b %h want v=1 %h", i, out_valid, out_code, c[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] words [5];
        logic [71:0] held;
        logic        held_v;
        int sent, rcvd;
        sent   = 0;
        rcvd   = 0;
        held   = '0;
        held_v = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = {$urandom, $urandom};
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            #1;
            if (out_valid && !out_ready) begin
                if (!held_v) begin
                    held   = out_code;
                    held_v = 1'b1;
                end else begin
                    n_checks++;
                    if (out_code !== held)
                        $display("FAIL stall_stable cyc%0d got %h want %h", cyc, out_code, held);
                    else n_pass++;
                end
            end
            if (cyc == 5) begin
                n_checks++;
                if (in_ready !== 1'b0 || sent != 2)
                    $display("FAIL bp_in_ready got rdy=%b accepts=%0d want rdy=0 accepts=2",
                             in_ready, sent);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (tb_extract(out_code) !== words[rcvd] || tb_syndrome(out_code) !== 7'd0)
                    $display("FAIL bp_word%0d got %h want %h", rcvd, tb_extract(out_code), words[rcvd]);
                else n_pass++;
                rcvd++;
            end
            if (sent < 5 && in_ready) begin
                in_data  = words[sent];
                in_valid = 1'b1;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (rcvd != 5) $display("FAIL bp_count got %0d want 5", rcvd);
        else n_pass++;
    endtask

    task automatic test_round_trip;
        logic [63:0] q [$];
        int got;
        int n_words;
        got     = 0;
        n_words = 1000;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < n_words; i++) begin
                    @(negedge clk);
                    for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
                    in_data  = {$urandom, $urandom};
                    in_valid = 1'b1;
                    q.push_back(in_data);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 1500 && got < n_words; cyc++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (q.size() == 0) begin
                            $display("FAIL rt_extra got %h want nothing", out_code);
                        end else begin
                            logic [63:0] exp;
                            exp = q.pop_front();
                            if (tb_extract(out_code) !== exp || tb_syndrome(out_code) !== 7'd0
                                || (^out_code) !== 1'b0)
                                $display("FAIL rt_word%0d got %h want data %h", got, out_code, exp);
                            else n_pass++;
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++;
        if (got != n_words) $display("FAIL rt_count got %0d want %0d", got, n_words);
        else n_pass++;
    endtask

`ifdef SECDED_ERR_INJ_EN
    task automatic test_inject;
        logic [63:0] d;
        logic [71:0] c;
        logic [6:0]  s;
        int p0, p1;
        out_ready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            d  = {$urandom, $urandom};
            p0 = (i == 32) ? 100 : int'($urandom_range(0, 71));
            p1 = (p0 + 1 + int'($urandom_range(0, 69))) % 72;
            @(negedge clk);
            in_data  = d;
            in_valid = 1'b1;
            inj_en   = 1'b1;
            inj_pos0 = p0[6:0];
            inj_pos1 = p1[6:0];
            inj_dbl  = (i >= 16 && i < 32);
            @(negedge clk);
            in_valid = 1'b0;
            inj_en   = 1'b0;
            @(negedge clk);
            c = out_code;
            s = tb_syndrome(c);
            n_checks++;
            if (i == 32) begin
                if (s !== 7'd0 || (^c) !== 1'b0 || tb_extract(c) !== d)
                    $display("FAIL inj_oob got %h want clean data %h", c, d);
                else n_pass++;
            end else if (i < 16) begin
                if ((^c) !== 1'b1 || s !== p0[6:0])
                    $display("FAIL inj_single%0d got syn=%0d par=%b want syn=%0d par=1", i, s, ^c, p0);
                else begin
                    c[s] = ~c[s];
                    if (tb_extract(c) !== d) $display("FAIL inj_fix%0d got %h want %h", i, tb_extract(c), d);
                    else n_pass++;
                end
            end else begin
                if ((^c) !== 1'b0 || s === 7'd0)
                    $display("FAIL inj_double%0d got syn=%0d par=%b want syn!=0 par=0", i, s, ^c);
                else n_pass++;
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        int stale;
        stale = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data  = 64'hDEAD_0000_0000_0000 + 64'(i);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        NSYSRESET = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 16'd0 || word_cnt4 !== 4'd0)
            $display("FAIL mid_word_cnt got %0d/%0d want 0/0", word_cnt, word_cnt4);
        else n_pass++;
        n_checks++;
        if (out_code !== 72'h0 || in_ready !== 1'b0)
            $display("FAIL mid_code_rdy got %h rdy=%b want 0 rdy=0", out_code, in_ready);
        else n_pass++;
        @(negedge clk);
        NSYSRESET = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL mid_stale got %0d want 0", stale);
        else n_pass++;
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
            in_data  = 64'(i) * 64'h0101_0101;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (word_cnt4 !== 4'd15) $display("FAIL sat_cnt4 got %0d want 15", word_cnt4);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 16'd20) $display("FAIL sat_cnt16 got %0d want 20", word_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_vectors();
        test_backpressure();
        test_round_trip();
`ifdef SECDED_ERR_INJ_EN
        test_inject();
`endif
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/secded_enc72.md
SECDED_ENC72 -- requirements
Module: secded_enc72

Interface
REQ-001 SHALL provide parameter CNT_W, default 16: width of the encoded-word counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port NSYSRESET, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 64 bits: data word to encode.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port out_code, output, 72 bits: SECDED codeword, in the same layout the 72-to-64 decoder (INn to real_data/ERRr) consumes.
REQ-008 SHALL have port out_valid, output, 1 bit: out_code is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream block accepts out_code.
REQ-010 SHALL have port word_cnt, output, CNT_W bits: saturating count of codewords delivered.

Function
REQ-011 SHALL transfer an input word only when in_valid and in_ready are both 1 on the same edge, and an output word only when out_valid and out_ready are both 1.
REQ-012 SHALL map the codeword by Hamming position p = 0..71 to out_code[p]:
- check bits at positions 1, 2, 4, 8, 16, 32, 64;
- in_data[0..63] at the remaining positions 3, 5, 6, 7, 9, ... 71, in ascending order;
- overall parity at position 0.
REQ-013 SHALL set the check bit at position 2^k to the XOR of all positions j in 1..71 (excluding 2^k itself) where bit k of j is 1.
REQ-014 SHALL set bit 0 to the XOR of bits 1..71, so that the full 72-bit word has even parity.
REQ-015 SHALL use a 2-stage pipeline:
- stage 1 registers the data and the seven check bits;
- stage 2 registers the packed word with overall parity;
- latency from accept to out_valid is exactly 2 cycles when there is no stall.
REQ-016 SHALL allow each stage to load when it is empty or when its contents are leaving in the same cycle. in_ready SHALL be 1 when stage 1 is empty or advances this cycle. Throughput SHALL be one word per cycle with no bubbles.
REQ-017 SHALL hold out_code and out_valid stable while out_valid=1 and out_ready=0. Words SHALL NOT be lost, duplicated or reordered.
REQ-018 SHALL allow an accept and a deliver on the same edge; the pipeline occupancy then stays unchanged.
REQ-019 SHALL increment word_cnt on each delivered word, holding at 2^CNT_W-1 once reached (no wrap).

Reset
REQ-020 SHALL, while NSYSRESET=0, immediately force: both stages empty, out_valid=0, out_code=0, word_cnt=0, in_ready=0.
REQ-021 SHALL discard any in-flight words on reset asserted mid-operation. in_ready SHALL go to 1 on the first clk edge after NSYSRESET deasserts.

Configuration
REQ-022 SHALL, with macro SECDED_ERR_INJ_EN defined, add the following ports for testing the decoder:
- inj_en: input, 1 bit;
- inj_pos0: input, 7 bits;
- inj_pos1: input, 7 bits;
- inj_dbl: input, 1 bit.
These are sampled with the accepted word. The block SHALL invert out_code[inj_pos0], and also out_code[inj_pos1] when inj_dbl=1. Positions above 71 are ignored.
REQ-023 SHALL, without SECDED_ERR_INJ_EN, omit those ports and the injection logic; the codeword is always clean.

Structure
REQ-024 SHALL place DATA_W=64, CODE_W=72, CHK_W=7, the check-position list and the data-to-position mapping function in shared package secded72_pkg. The decoder SHALL reuse the same package.
REQ-025 SHALL implement the check-bit generator as combinational sub-module secded72_parity (64-bit data in, 7 check bits out).

Verification
REQ-026 SHALL cover: in_data=0, out_ready=1 -> out_code=72'h0 two cycles after accept; word_cnt=1.
REQ-027 SHALL cover: in_data=64'h1 -> out_code=72'h00_0000_0000_0000_000F.
REQ-028 SHALL cover the round trip: 1000 random words through secded_enc72 into the decoder -> real_data equals in_data and ERRr=0 for every word. With SECDED_ERR_INJ_EN, a single flip is corrected with ERRr=0 and a double flip gives ERRr=1.
REQ-029 SHALL cover backpressure: 5 words sent back-to-back with out_ready=0 for 6 cycles -> in_ready drops after 2 accepts, out_code stays stable while stalled, then all 5 words arrive in order with none lost.
REQ-030 SHALL cover reset mid-operation: NSYSRESET=0 with 2 words in flight -> out_valid=0 and word_cnt=0 at once, and no stale word after release.
REQ-031 SHALL cover counter saturation: CNT_W=4 and 20 words delivered -> word_cnt=15.
